instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the main instruction decoder. Accepts symbolic RV32I instruction descriptors (class, register fields, funct fields, immediate) over a valid/ready stream. It packs each descriptor into a 32-bit machine word using the opcode and immediate layout the decoder expects, and writes the words sequentially into instruction memory over a req/ack write port. It is used by the boot/program-load path and the verification harness to fill instruction memory ahead of the core.

Parameters:
ADDR_W, 12, byte-address width of mem_addr
BASE_ADDR, 0, first write address after reset or start
FIFO_DEPTH, 2, encoded-word buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; resets write address to BASE_ADDR and clears word_count
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid & in_ready
in_class  input  4  0 LOAD, 1 STORE, 2 R_TYPE, 3 I_TYPE, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC, 8 JALR; other values illegal
in_rd  input  5  destination register
in_rs1  input  5  source 1
in_rs2  input  5  source 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R_TYPE, and I_TYPE shifts)
in_imm  input  32  immediate, sign-extended byte value (U: bits 31:12 used)
mem_req  output  1  write request
mem_addr  output  ADDR_W  word-aligned byte address
mem_wdata  output  32  encoded instruction
mem_ack  input  1  memory accepted write this cycle
word_count  output  ADDR_W  words written since reset/start
busy  output  1  FIFO non-empty or mem_req high
err  output  1  one-cycle pulse on dropped descriptor

Behaviour:
- Reset (async): FIFO empty; mem_req=0; mem_addr=BASE_ADDR; mem_wdata=0; word_count=0; err=0; in_ready=1.
- in_ready = FIFO not full. Encoding is combinational on input and pushed into the FIFO on handshake (1-cycle latency to FIFO).
- Encoding:
  - LOAD op 0000011, I_TYPE op 0010011, JALR op 1100111 (funct3 forced 000): {imm[11:0],rs1,f3,rd,op}.
  - I_TYPE with f3=001/101: {funct7,imm[4:0],rs1,f3,rd,op}.
  - STORE op 0100011: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - R_TYPE op 0110011: {f7,rs2,rs1,f3,rd,op}.
  - BRANCH op 1100011: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JAL op 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - LUI op 0110111, AUIPC op 0010111: {imm[31:12],rd,op}.
- Drop rules: an illegal class, or BRANCH/JAL with imm[0]=1, is accepted (in_ready honoured), not pushed, and produces an err pulse the next cycle.
- Write FSM:
  - IDLE: if FIFO non-empty, load head into mem_wdata, pop, and go to REQ with mem_req=1 on the next cycle.
  - REQ: hold mem_req, mem_addr and mem_wdata stable until mem_ack. On ack: mem_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1, mem_req drops; go to IDLE, or stay in REQ with the next word if the FIFO is non-empty (back-to-back, one word per ack).
- Simultaneous push and pop on a full FIFO is allowed; in_ready reflects full before the pop.
- start while in REQ: the current write completes at the old address; subsequent writes restart at BASE_ADDR; word_count clears when start is applied. start does not flush the FIFO.
- Reset mid-REQ: mem_req drops immediately; FIFO contents are lost.

Decomposition:
- Shared package riscv_pkg: opcode localparams (same values as the decoder), instr_class_e enum, and an encode_instr function usable by both RTL and the bench.
- One sub-module: sync_fifo (width 32, depth FIFO_DEPTH, full/empty flags).

Test Plan:
- Reset, then I_TYPE rd=1 rs1=0 f3=0 imm=5, mem_ack tied 1 -> mem_wdata=0x00500093 at addr 0; word_count=1.
- STORE rs1=1 rs2=2 f3=010 imm=8, then BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0x0020A423 @0, 0xFE208EE3 @4.
- JAL rd=1 imm=8; LUI rd=5 imm=0x12345000 -> 0x008000EF, 0x123452B7 at consecutive addresses.
- Hold mem_ack=0 and push 4 descriptors -> in_ready low after FIFO_DEPTH+1 accepted (1 in REQ); release ack -> all written in order, addresses 0,4,8,12.
- in_class=15, and JAL imm=3 -> no mem_req, err pulses once each, word_count unchanged.
- Write 3 words, pulse start during REQ -> current word at 8, next at BASE_ADDR; async rst mid-REQ -> mem_req=0 in the same cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, descriptor classes and the descriptor-to-word encoder
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_STORE  = 4'd1,
    CLS_R_TYPE = 4'd2,
    CLS_I_TYPE = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_LUI    = 4'd6,
    CLS_AUIPC  = 4'd7,
    CLS_JALR   = 4'd8
  } instr_class_e;

  // Illegal classes and odd branch/jump offsets cannot be represented; they are dropped.
  function automatic logic instr_legal(input logic [3:0] cls, input logic [31:0] imm);
    logic ok;
    ok = (cls <= 4'd8);
    if ((cls == CLS_BRANCH || cls == CLS_JAL) && imm[0]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] encode_instr(
    input logic [3:0]  cls,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (cls)
      CLS_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      CLS_I_TYPE: w = (f3 == 3'b001 || f3 == 3'b101) ? {f7, imm[4:0], rs1, f3, rd, OP_I_TYPE}
                                                     : {imm[11:0], rs1, f3, rd, OP_I_TYPE};
      CLS_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      CLS_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      CLS_R_TYPE: w = {f7, rs2, rs1, f3, rd, OP_R_TYPE};
      CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_LUI:    w = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:  w = {imm[31:12], rd, OP_AUIPC};
      default:    w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags, power-of-two depth
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I descriptors and streams the words into instruction memory
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              err
);

  typedef enum logic {S_IDLE, S_REQ} wr_state_e;

  wr_state_e   state;
  logic [31:0] enc_word, head;
  logic        legal, accept, push, pop, full, empty;
  logic        restart_pend;

  assign enc_word = encode_instr(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  assign legal    = instr_legal(in_class, in_imm);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = !empty && ((state == S_IDLE) || (state == S_REQ && mem_ack));
  assign busy     = !empty || mem_req;

  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'h0;
      word_count   <= '0;
      err          <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      err <= accept && !legal;
      case (state)
        S_IDLE: begin
          if (start) mem_addr <= BASE_ADDR;
          if (!empty) begin
            mem_wdata <= head;
            mem_req   <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            // A start seen during this write redirects only the writes after it.
            mem_addr     <= (start || restart_pend) ? BASE_ADDR : mem_addr + ADDR_W'(4);
            restart_pend <= 1'b0;
            word_count   <= word_count + 1'b1;
            if (!empty) begin
              mem_wdata <= head;
            end else begin
              mem_req <= 1'b0;
              state   <= S_IDLE;
            end
          end else if (start) begin
            restart_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (start) word_count <= '0;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b1;
  logic [11:0] word_count;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [31:0] exp_word_q[$];
  logic [11:0] exp_addr_q[$];

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .word_count(word_count), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted memory write is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_pulses++;
      if (mem_req && mem_ack) begin
        if (exp_word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got 0x%08h @0x%03h expected none", mem_wdata, mem_addr);
        end else begin
          chk("write_data", mem_wdata, exp_word_q.pop_front());
          chk("write_addr", {20'h0, mem_addr}, {20'h0, exp_addr_q.pop_front()});
        end
      end
    end
  end

  task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input bit expect_write,
                      input logic [31:0] exp_word, input logic [11:0] exp_addr);
    int n;
    in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    if (expect_write) begin
      exp_word_q.push_back(exp_word);
      exp_addr_q.push_back(exp_addr);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: busy=1 expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int base_err;
    logic [11:0] wc;

    // Reset state
    #12;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_word_count", {20'h0, word_count}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // addi x1, x0, 5
    send(4'd3, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b1, 32'h00500093, 12'h000);
    drain();
    chk("wc_after_first", {20'h0, word_count}, 32'd1);

    // sw x2, 8(x1); beq x1, x2, -4
    pulse_start();
    send(4'd1, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8, 1'b1, 32'h0020A423, 12'h000);
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, 12'h004);
    drain();

    // jal x1, 8; lui x5, 0x12345
    pulse_start();
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8, 1'b1, 32'h008000EF, 12'h000);
    send(4'd6, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000, 1'b1, 32'h123452B7, 12'h004);
    drain();
    chk("wc_two", {20'h0, word_count}, 32'd2);

    // Remaining classes, with a JALR carrying a non-zero funct3 that must be forced to 000
    pulse_start();
    send(4'd2, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1'b1, 32'h002081B3, 12'h000);
    send(4'd2, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 1'b1, 32'h402081B3, 12'h004);
    send(4'd8, 5'd1, 5'd2, 5'd0, 3'b111, 7'h00, 32'd0, 1'b1, 32'h000100E7, 12'h008);
    send(4'd3, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3, 1'b1, 32'h40315093, 12'h00C);
    send(4'd0, 5'd5, 5'd1, 5'd0, 3'b010, 7'h00, 32'd4, 1'b1, 32'h0040A283, 12'h010);
    send(4'd7, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h00001000, 1'b1, 32'h00001097, 12'h014);
    drain();
    chk("wc_six", {20'h0, word_count}, 32'd6);

    // Back-pressure: one word in REQ plus a full FIFO, fourth descriptor stalls
    pulse_start();
    mem_ack = 1'b0;
    send(4'd3, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1, 1'b1, 32'h00100093, 12'h000);
    send(4'd3, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2, 1'b1, 32'h00200113, 12'h004);
    send(4'd3, 5'd3, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3, 1'b1, 32'h00300193, 12'h008);
    repeat (3) @(negedge clk);
    chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    chk("stall_req", {31'h0, mem_req}, 32'h1);
    chk("stall_addr", {20'h0, mem_addr}, 32'h0);
    chk("stall_wdata", mem_wdata, 32'h00100093);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    send(4'd3, 5'd4, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4, 1'b1, 32'h00400213, 12'h00C);
    drain();
    chk("wc_stall", {20'h0, word_count}, 32'd4);

    // Dropped descriptors
    base_err = err_pulses;
    wc = word_count;
    send(4'd15, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0, 1'b0, 32'h0, 12'h0);
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3, 1'b0, 32'h0, 12'h0);
    repeat (3) @(negedge clk);
    chk("err_pulses", err_pulses - base_err, 32'd2);
    chk("drop_wc", {20'h0, word_count}, {20'h0, wc});
    chk("drop_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk);
    #1;

    // start during REQ: current word at 8, next word back at BASE_ADDR
    pulse_start();
    send(4'd3, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd10, 1'b1, 32'h00A00093, 12'h000);
    send(4'd3, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd11, 1'b1, 32'h00B00113, 12'h004);
    drain();
    mem_ack = 1'b0;
    send(4'd3, 5'd3, 5'd0, 5'd0, 3'b000, 7'h00, 32'd12, 1'b1, 32'h00C00193, 12'h008);
    send(4'd3, 5'd4, 5'd0, 5'd0, 3'b000, 7'h00, 32'd13, 1'b1, 32'h00D00213, 12'h000);
    pulse_start();
    chk("start_wc_clear", {20'h0, word_count}, 32'd0);
    mem_ack = 1'b1;
    drain();
    chk("start_wc", {20'h0, word_count}, 32'd2);

    // Asynchronous reset while a request is outstanding
    mem_ack = 1'b0;
    send(4'd3, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'd14, 1'b0, 32'h0, 12'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'h0, mem_req}, 32'h0);
    chk("async_rst_addr", {20'h0, mem_addr}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_word_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish expected finish");
    $fatal(1);
  end

endmodule
